// File: rtl/uc_pkg.sv
// Shared definitions for the uc_irq_param control unit.
// Latency: none (constants and types only).
// Backpressure: not applicable.
// Contents: opcode encodings, decode prefixes, the control-vector struct and its NOP value.
package uc_pkg;

  // Full 6-bit opcodes of the control-flow and interrupt instructions
  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_JN   = 6'b110011;
  localparam logic [5:0] OP_CALL = 6'b110100;
  localparam logic [5:0] OP_RET  = 6'b110101;
  localparam logic [5:0] OP_SKZ  = 6'b110110;
  localparam logic [5:0] OP_SKNZ = 6'b110111;
  localparam logic [5:0] OP_RETI = 6'b111000;
  localparam logic [5:0] OP_EI   = 6'b111001;
  localparam logic [5:0] OP_DI   = 6'b111010;

  // Prefixes on opcode[5:2]; an ALU op is any opcode with bit 5 clear,
  // so only the top bit of PFX_ALU is actually compared.
  localparam logic [3:0] PFX_ALU  = 4'b0000;
  localparam logic [3:0] PFX_LOAD = 4'b1000;
  localparam logic [3:0] PFX_IN   = 4'b1001;
  localparam logic [3:0] PFX_OUT  = 4'b1010;

  // Datapath control vector (owe and irq_id are parameter-sized, kept outside)
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic       wen;
    logic       wesp;
    logic       push;
    logic       pop;
    logic       s_inp;
    logic       s_outp;
    logic       s_vec;
    logic       fin_interrup;
    logic [2:0] op_alu;
  } ctrl_t;

  // NOP: advance the PC, touch nothing else
  localparam ctrl_t CTRL_NOP = '{s_inc: 1'b1, default: '0};

endpackage

// File: rtl/uc_irq_prio.sv
// Interrupt pending register with rising-edge capture and lowest-index priority select.
// Latency: a rising irq edge shows up in any_pending/irq_id one cycle later.
// Backpressure: none; a pending bit holds until cleared by clr_vld for its index.
// Ports: clk, reset (async active-low), irq[NIRQ] level requests, clr_vld/clr_id
//        clear request from the entry logic, any_pending and irq_id (lowest set index).
module uc_irq_prio
  import uc_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            clr_vld,
  input  logic [IW-1:0]   clr_id,
  output logic            any_pending,
  output logic [IW-1:0]   irq_id
);

  logic [NIRQ-1:0] irq_q, irq_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr_mask;

  always_comb begin
    irq_d    = irq;
    rise     = irq & ~irq_q;
    clr_mask = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (clr_vld && (clr_id == IW'(i))) clr_mask[i] = 1'b1;
    end
    // A fresh edge arriving on the cycle its line is being entered survives the clear
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_comb begin
    irq_id = '0;
    // Walk downwards so the lowest set index is the last assignment
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) irq_id = IW'(i);
    end
  end

  assign any_pending = |pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/uc_irq_param.sv
// Control unit: combinational opcode decode with skip counter and single-level interrupt entry/return.
// Latency: control outputs are combinational from opcode/flags/state; state updates at the next edge.
// Backpressure: none; one instruction decoded every cycle, an interrupt entry replaces the current one.
// Ports: clk, reset (async active-low), opcode/port_id/s_z/s_n/irq in; datapath controls
//        (s_inc..s_vec, owe, op_alu), fin_interrup, irq_id and ie_o out.
module uc_irq_param
  import uc_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int NIRQ   = 4,
  parameter int SKIP_N = 2,
  parameter int PW     = 2,
  parameter int IW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [PW-1:0]     port_id,
  input  logic              s_z,
  input  logic              s_n,
  input  logic [NIRQ-1:0]   irq,
  output logic              s_inc,
  output logic              s_inm,
  output logic              we3,
  output logic              wez,
  output logic              wen,
  output logic              wesp,
  output logic              push,
  output logic              pop,
  output logic              s_inp,
  output logic              s_outp,
  output logic              s_vec,
  output logic [NPORTS-1:0] owe,
  output logic [2:0]        op_alu,
  output logic              fin_interrup,
  output logic [IW-1:0]     irq_id,
  output logic              ie_o
);

  localparam int SW = (SKIP_N < 1) ? 1 : $clog2(SKIP_N + 1);

  logic [SW-1:0]     skip_cnt_q, skip_cnt_d;
  logic              ie_q, ie_d;
  logic              in_isr_q, in_isr_d;

  logic              any_pending;
  logic [IW-1:0]     prio_id;
  logic              entry;
  logic              clr_vld;

  ctrl_t             ctrl;
  ctrl_t             ctrl_out;
  logic [NPORTS-1:0] owe_int;
  logic [NPORTS-1:0] owe_out;
  logic [IW-1:0]     irq_id_int;
  logic [IW-1:0]     irq_id_out;

  uc_irq_prio #(
    .NIRQ (NIRQ),
    .IW   (IW)
  ) u_prio (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .clr_vld     (clr_vld),
    .clr_id      (prio_id),
    .any_pending (any_pending),
    .irq_id      (prio_id)
  );

  always_comb begin
    ctrl       = CTRL_NOP;
    owe_int    = '0;
    irq_id_int = '0;
    clr_vld    = 1'b0;
    skip_cnt_d = skip_cnt_q;
    ie_d       = ie_q;
    in_isr_d   = in_isr_q;

    entry = ie_q & ~in_isr_q & (skip_cnt_q == '0) & any_pending;

    if (skip_cnt_q != '0) begin
      // Skipped slot: NOP outputs and no side effects, skip opcodes included
      skip_cnt_d = skip_cnt_q - SW'(1);
    end else if (entry) begin
      // Push the current PC and vector; this instruction is re-fetched after reti
      ctrl       = '0;
      ctrl.s_vec = 1'b1;
      ctrl.wesp  = 1'b1;
      ctrl.push  = 1'b1;
      irq_id_int = prio_id;
      clr_vld    = 1'b1;
      in_isr_d   = 1'b1;
      ie_d       = 1'b0;
    end else if (opcode[5] == PFX_ALU[3]) begin
      ctrl.we3    = 1'b1;
      ctrl.wez    = 1'b1;
      ctrl.wen    = 1'b1;
      ctrl.op_alu = opcode[4:2];
    end else begin
      case (opcode[5:2])
        PFX_LOAD: begin
          ctrl.s_inm = 1'b1;
          ctrl.we3   = 1'b1;
        end
        PFX_IN: begin
          ctrl.we3   = 1'b1;
          ctrl.s_inp = 1'b1;
        end
        PFX_OUT: begin
          ctrl.s_outp = 1'b1;
          // Out-of-range port ids match no bit and leave owe clear
          for (int i = 0; i < NPORTS; i++) begin
            if (port_id == PW'(i)) owe_int[i] = 1'b1;
          end
        end
        default: begin
          case (opcode)
            OP_J:    ctrl.s_inc = 1'b0;
            OP_JZ:   ctrl.s_inc = ~s_z;
            OP_JNZ:  ctrl.s_inc = s_z;
            OP_JN:   ctrl.s_inc = ~s_n;
            OP_CALL: begin
              ctrl.s_inc = 1'b0;
              ctrl.wesp  = 1'b1;
              ctrl.push  = 1'b1;
            end
            OP_RET: begin
              ctrl.s_inc = 1'b0;
              ctrl.wesp  = 1'b1;
              ctrl.pop   = 1'b1;
            end
            OP_SKZ:  if (s_z)  skip_cnt_d = SW'(SKIP_N);
            OP_SKNZ: if (!s_z) skip_cnt_d = SW'(SKIP_N);
            OP_RETI: begin
              // Also valid outside an ISR: still pops and re-enables
              ctrl.s_inc        = 1'b0;
              ctrl.wesp         = 1'b1;
              ctrl.pop          = 1'b1;
              ctrl.fin_interrup = 1'b1;
              in_isr_d          = 1'b0;
              ie_d              = 1'b1;
            end
            OP_EI:   ie_d = 1'b1;
            OP_DI:   ie_d = 1'b0;
            default: ;
          endcase
        end
      endcase
    end
  end

  // Everything, s_inc included, is forced low while reset is asserted
  always_comb begin
    ctrl_out   = ctrl;
    owe_out    = owe_int;
    irq_id_out = irq_id_int;
    if (!reset) begin
      ctrl_out   = '0;
      owe_out    = '0;
      irq_id_out = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_cnt_q <= '0;
      ie_q       <= 1'b0;
      in_isr_q   <= 1'b0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
      ie_q       <= ie_d;
      in_isr_q   <= in_isr_d;
    end
  end

  assign s_inc        = ctrl_out.s_inc;
  assign s_inm        = ctrl_out.s_inm;
  assign we3          = ctrl_out.we3;
  assign wez          = ctrl_out.wez;
  assign wen          = ctrl_out.wen;
  assign wesp         = ctrl_out.wesp;
  assign push         = ctrl_out.push;
  assign pop          = ctrl_out.pop;
  assign s_inp        = ctrl_out.s_inp;
  assign s_outp       = ctrl_out.s_outp;
  assign s_vec        = ctrl_out.s_vec;
  assign fin_interrup = ctrl_out.fin_interrup;
  assign op_alu       = ctrl_out.op_alu;
  assign owe          = owe_out;
  assign irq_id       = irq_id_out;
  assign ie_o         = ie_q;

endmodule

// File: tb/tb_uc_irq_param.sv
// Bench for uc_irq_param: decode table plus hand-written interrupt/skip/reset sequences.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: not applicable.
module tb_uc_irq_param;

  // Expected-flag bit positions: {s_inc,s_inm,we3,wez,wen,wesp,push,pop,s_inp,s_outp,s_vec,fin}
  localparam logic [11:0] F_INC  = 12'h800;
  localparam logic [11:0] F_INM  = 12'h400;
  localparam logic [11:0] F_WE3  = 12'h200;
  localparam logic [11:0] F_WEZ  = 12'h100;
  localparam logic [11:0] F_WEN  = 12'h080;
  localparam logic [11:0] F_WESP = 12'h040;
  localparam logic [11:0] F_PUSH = 12'h020;
  localparam logic [11:0] F_POP  = 12'h010;
  localparam logic [11:0] F_INP  = 12'h008;
  localparam logic [11:0] F_OUTP = 12'h004;
  localparam logic [11:0] F_VEC  = 12'h002;
  localparam logic [11:0] F_FIN  = 12'h001;
  localparam logic [11:0] F_ALU  = F_INC | F_WE3 | F_WEZ | F_WEN;
  localparam logic [11:0] F_ENT  = F_VEC | F_WESP | F_PUSH;
  localparam logic [11:0] F_RTI  = F_WESP | F_POP | F_FIN;

  localparam logic [5:0] C_ALU  = 6'b000100;
  localparam logic [5:0] C_LOAD = 6'b100001;
  localparam logic [5:0] C_J    = 6'b110000;
  localparam logic [5:0] C_SKZ  = 6'b110110;
  localparam logic [5:0] C_SKNZ = 6'b110111;
  localparam logic [5:0] C_RETI = 6'b111000;
  localparam logic [5:0] C_EI   = 6'b111001;
  localparam logic [5:0] C_DI   = 6'b111010;
  localparam logic [5:0] C_NOP  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [1:0] port_id;
  logic       s_z, s_n;
  logic [3:0] irq;

  logic       s_inc, s_inm, we3, wez, wen, wesp, push, pop, s_inp, s_outp, s_vec, fin_interrup, ie_o;
  logic [3:0] owe;
  logic [2:0] op_alu;
  logic [1:0] irq_id;

  logic       s_inc3, s_inm3, we33, wez3, wen3, wesp3, push3, pop3, s_inp3, s_outp3, s_vec3, fin3, ie_o3;
  logic [2:0] owe3;
  logic [2:0] op_alu3;
  logic [1:0] irq_id3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uc_irq_param dut (
    .clk(clk), .reset(reset), .opcode(opcode), .port_id(port_id), .s_z(s_z), .s_n(s_n), .irq(irq),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .wen(wen), .wesp(wesp), .push(push),
    .pop(pop), .s_inp(s_inp), .s_outp(s_outp), .s_vec(s_vec), .owe(owe), .op_alu(op_alu),
    .fin_interrup(fin_interrup), .irq_id(irq_id), .ie_o(ie_o)
  );

  uc_irq_param #(.NPORTS(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .port_id(port_id), .s_z(s_z), .s_n(s_n), .irq(irq),
    .s_inc(s_inc3), .s_inm(s_inm3), .we3(we33), .wez(wez3), .wen(wen3), .wesp(wesp3), .push(push3),
    .pop(pop3), .s_inp(s_inp3), .s_outp(s_outp3), .s_vec(s_vec3), .owe(owe3), .op_alu(op_alu3),
    .fin_interrup(fin3), .irq_id(irq_id3), .ie_o(ie_o3)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  pid;
    logic        z;
    logic        n;
    logic [11:0] flags;
    logic [2:0]  alu;
    logic [3:0]  owe;
    logic [2:0]  owe3;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [18:0] obs();
    return {s_inc, s_inm, we3, wez, wen, wesp, push, pop, s_inp, s_outp, s_vec, fin_interrup, op_alu, owe};
  endfunction

  function automatic logic [17:0] obs3();
    return {s_inc3, s_inm3, we33, wez3, wen3, wesp3, push3, pop3, s_inp3, s_outp3, s_vec3, fin3, op_alu3, owe3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string nm, input logic [11:0] f, input logic [2:0] a, input logic [3:0] o);
    chk(nm, 32'(obs()), 32'({f, a, o}));
  endtask

  task automatic cyc(input logic [5:0] op, input logic [1:0] pid, input logic z, input logic n,
                     input logic [3:0] iv);
    @(posedge clk);
    #1;
    opcode  = op;
    port_id = pid;
    s_z     = z;
    s_n     = n;
    irq     = iv;
    @(negedge clk);
  endtask

  task automatic op1(input logic [5:0] op, input logic [3:0] iv);
    cyc(op, 2'd0, 1'b0, 1'b0, iv);
  endtask

  initial begin
    vecs[0]  = '{C_ALU,     2'd0, 1'b0, 1'b0, F_ALU,                  3'b001, 4'b0000, 3'b000};
    vecs[1]  = '{6'b011111, 2'd0, 1'b1, 1'b1, F_ALU,                  3'b111, 4'b0000, 3'b000};
    vecs[2]  = '{C_LOAD,    2'd0, 1'b0, 1'b0, F_INC | F_INM | F_WE3,  3'b000, 4'b0000, 3'b000};
    vecs[3]  = '{6'b100110, 2'd0, 1'b0, 1'b0, F_INC | F_WE3 | F_INP,  3'b000, 4'b0000, 3'b000};
    vecs[4]  = '{6'b101000, 2'd2, 1'b0, 1'b0, F_INC | F_OUTP,         3'b000, 4'b0100, 3'b100};
    vecs[5]  = '{6'b101011, 2'd0, 1'b0, 1'b0, F_INC | F_OUTP,         3'b000, 4'b0001, 3'b001};
    vecs[6]  = '{6'b101001, 2'd3, 1'b0, 1'b0, F_INC | F_OUTP,         3'b000, 4'b1000, 3'b000};
    vecs[7]  = '{C_J,       2'd0, 1'b0, 1'b0, 12'h000,                3'b000, 4'b0000, 3'b000};
    vecs[8]  = '{6'b110001, 2'd0, 1'b1, 1'b0, 12'h000,                3'b000, 4'b0000, 3'b000};
    vecs[9]  = '{6'b110001, 2'd0, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[10] = '{6'b110010, 2'd0, 1'b1, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[11] = '{6'b110010, 2'd0, 1'b0, 1'b0, 12'h000,                3'b000, 4'b0000, 3'b000};
    vecs[12] = '{6'b110011, 2'd0, 1'b0, 1'b1, 12'h000,                3'b000, 4'b0000, 3'b000};
    vecs[13] = '{6'b110011, 2'd0, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[14] = '{6'b110100, 2'd0, 1'b0, 1'b0, F_WESP | F_PUSH,        3'b000, 4'b0000, 3'b000};
    vecs[15] = '{6'b110101, 2'd0, 1'b0, 1'b0, F_WESP | F_POP,         3'b000, 4'b0000, 3'b000};
    vecs[16] = '{C_SKZ,     2'd0, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[17] = '{C_SKNZ,    2'd0, 1'b1, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[18] = '{6'b111011, 2'd0, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[19] = '{6'b101100, 2'd1, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};
    vecs[20] = '{C_RETI,    2'd0, 1'b0, 1'b0, F_RTI,                  3'b000, 4'b0000, 3'b000};
    vecs[21] = '{C_DI,      2'd0, 1'b0, 1'b0, F_INC,                  3'b000, 4'b0000, 3'b000};

    // Reset held low during an ALU op: every output low
    reset = 1'b0; opcode = C_ALU; port_id = 2'd0; s_z = 1'b0; s_n = 1'b0; irq = 4'd0;
    repeat (2) @(negedge clk);
    chk_ctrl("rst_ctrl", 12'h000, 3'b000, 4'b0000);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    chk("rst_ie", 32'(ie_o), 32'd0);
    chk("rst_dut3", 32'(obs3()), 32'd0);
    chk("rst_dut3_id_ie", 32'({irq_id3, ie_o3}), 32'd0);
    reset = 1'b1;
    op1(C_ALU, 4'd0);
    chk_ctrl("post_rst_alu", F_ALU, 3'b001, 4'b0000);

    // Decode table
    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].op, vecs[i].pid, vecs[i].z, vecs[i].n, 4'd0);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'({vecs[i].flags, vecs[i].alu, vecs[i].owe}));
      chk($sformatf("vec%0d_np3", i), 32'(obs3()), 32'({vecs[i].flags, vecs[i].alu, vecs[i].owe3}));
    end

    // sknz taken: two slots skipped, third executes
    cyc(C_SKNZ, 2'd0, 1'b0, 1'b0, 4'd0); chk_ctrl("sknz", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("skip1_alu", F_INC, 3'b000, 4'b0000);
    op1(C_J, 4'd0);                      chk_ctrl("skip2_j", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("after_skip", F_ALU, 3'b001, 4'b0000);

    // A skip opcode inside a skip window must not re-arm the counter
    cyc(C_SKZ, 2'd0, 1'b1, 1'b0, 4'd0);  chk_ctrl("skz", F_INC, 3'b000, 4'b0000);
    cyc(C_SKZ, 2'd0, 1'b1, 1'b0, 4'd0);  chk_ctrl("skz_ignored", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("skip_alu", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("no_rearm", F_ALU, 3'b001, 4'b0000);

    // Two simultaneous requests during a load: lowest index first, then the other after reti
    op1(C_EI, 4'd0);                     chk_ctrl("ei", F_INC, 3'b000, 4'b0000);
    chk("ei_ie_before", 32'(ie_o), 32'd0);
    op1(C_LOAD, 4'b0110);                chk_ctrl("load_runs", F_INC | F_INM | F_WE3, 3'b000, 4'b0000);
    chk("ie_on", 32'(ie_o), 32'd1);
    op1(C_LOAD, 4'd0);                   chk_ctrl("entry1", F_ENT, 3'b000, 4'b0000);
    chk("entry1_id", 32'(irq_id), 32'd1);
    op1(C_ALU, 4'd0);                    chk_ctrl("isr_alu", F_ALU, 3'b001, 4'b0000);
    chk("isr_ie_off", 32'(ie_o), 32'd0);
    op1(C_RETI, 4'd0);                   chk_ctrl("reti1", F_RTI, 3'b000, 4'b0000);
    op1(C_LOAD, 4'd0);                   chk_ctrl("entry2", F_ENT, 3'b000, 4'b0000);
    chk("entry2_id", 32'(irq_id), 32'd2);
    chk("entry2_ie", 32'(ie_o), 32'd1);

    // No nesting: ei inside the ISR, a new request waits for reti
    op1(C_EI, 4'd0);                     chk_ctrl("isr_ei", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'b1000);                 chk_ctrl("isr_irq3", F_INC, 3'b000, 4'b0000);
    chk("isr_ie_set", 32'(ie_o), 32'd1);
    op1(C_NOP, 4'd0);                    chk_ctrl("no_nest1", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'd0);                    chk_ctrl("no_nest2", F_INC, 3'b000, 4'b0000);
    op1(C_RETI, 4'd0);                   chk_ctrl("reti2", F_RTI, 3'b000, 4'b0000);
    op1(C_NOP, 4'd0);                    chk_ctrl("entry3", F_ENT, 3'b000, 4'b0000);
    chk("entry3_id", 32'(irq_id), 32'd3);
    op1(C_RETI, 4'd0);                   chk_ctrl("reti3", F_RTI, 3'b000, 4'b0000);

    // di: request held pending until ei
    op1(C_DI, 4'd0);                     chk_ctrl("di", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'b0001);                 chk("di_ie_off", 32'(ie_o), 32'd0);
    op1(C_NOP, 4'd0);                    chk_ctrl("di_hold1", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'd0);                    chk_ctrl("di_hold2", F_INC, 3'b000, 4'b0000);
    op1(C_EI, 4'd0);                     chk_ctrl("ei_late", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'd0);                    chk_ctrl("entry4", F_ENT, 3'b000, 4'b0000);
    chk("entry4_id", 32'(irq_id), 32'd0);
    op1(C_RETI, 4'd0);                   chk_ctrl("reti4", F_RTI, 3'b000, 4'b0000);

    // Request arriving during a skip window waits until the counter drains
    cyc(C_SKZ, 2'd0, 1'b1, 1'b0, 4'd0);  chk_ctrl("skz_ie", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'b0001);                 chk_ctrl("skip_irq1", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("skip_irq2", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("entry5", F_ENT, 3'b000, 4'b0000);
    chk("entry5_id", 32'(irq_id), 32'd0);
    op1(C_RETI, 4'd0);                   chk_ctrl("reti5", F_RTI, 3'b000, 4'b0000);

    // Reset inside an ISR with another request pending: both are lost
    op1(C_NOP, 4'b0100);                 chk_ctrl("pre_rst_req", F_INC, 3'b000, 4'b0000);
    op1(C_NOP, 4'd0);                    chk_ctrl("entry6", F_ENT, 3'b000, 4'b0000);
    chk("entry6_id", 32'(irq_id), 32'd2);
    op1(C_NOP, 4'b0010);                 chk_ctrl("isr_req", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("isr_alu2", F_ALU, 3'b001, 4'b0000);
    #2 reset = 1'b0;
    #1 chk_ctrl("async_rst", 12'h000, 3'b000, 4'b0000);
    @(negedge clk);
    chk_ctrl("rst_hold", 12'h000, 3'b000, 4'b0000);
    chk("rst_hold_ie", 32'(ie_o), 32'd0);
    reset = 1'b1;
    op1(C_EI, 4'd0);                     chk_ctrl("ei_after_rst", F_INC, 3'b000, 4'b0000);
    op1(C_ALU, 4'd0);                    chk_ctrl("pending_lost", F_ALU, 3'b001, 4'b0000);
    chk("ie_after_rst", 32'(ie_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
